// File: rtl/crc_pkg.sv
// Shared types and constants for the serial CRC engine: FSM state encoding and
// the 2-bit result codes reported on status.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] NONE    = 2'b00;
  localparam logic [1:0] PASS    = 2'b01;
  localparam logic [1:0] FAIL    = 2'b10;
  localparam logic [1:0] BADPOLY = 2'b11;

endpackage

// File: rtl/crc_engine_if.sv
// Request/result bundle of crc_engine. Optional macro CRC_INJECT_EN adds the
// inject_err request bit.
interface crc_engine_if #(
  parameter int unsigned G_W = 5,
  parameter int unsigned D_W = 14
);

  logic                   start;
  logic                   mode;
  logic [D_W-1:0]         data_in;
  logic [G_W-2:0]         crc_in;
  logic [G_W-1:0]         G;
`ifdef CRC_INJECT_EN
  logic                   inject_err;
`endif
  logic                   busy;
  logic                   done;
  logic                   error;
  logic [1:0]             status;
  logic [G_W-2:0]         remainder;
  logic [D_W+G_W-2:0]     codeword;

`ifdef CRC_INJECT_EN
  modport master (
    output start, mode, data_in, crc_in, G, inject_err,
    input  busy, done, error, status, remainder, codeword
  );
  modport slave (
    input  start, mode, data_in, crc_in, G, inject_err,
    output busy, done, error, status, remainder, codeword
  );
`else
  modport master (
    output start, mode, data_in, crc_in, G,
    input  busy, done, error, status, remainder, codeword
  );
  modport slave (
    input  start, mode, data_in, crc_in, G,
    output busy, done, error, status, remainder, codeword
  );
`endif

endinterface

// File: rtl/crc_div_step.sv
// One polynomial long-division step: shift the next message bit into the
// remainder and subtract (XOR) the generator when the outgoing bit is set.
module crc_div_step #(
  parameter int unsigned G_W = 5
) (
  input  logic [G_W-2:0] i_rem,
  input  logic           i_bit,
  input  logic [G_W-2:0] i_poly,
  output logic [G_W-2:0] o_rem
);

  logic w_fb;

  assign w_fb = i_rem[G_W-2];

  // A 1-bit remainder has no lower bits to carry over.
  if (G_W == 2) begin : g_narrow
    assign o_rem = i_bit ^ (w_fb & i_poly[0]);
  end else begin : g_wide
    assign o_rem = {i_rem[G_W-3:0], i_bit} ^ (w_fb ? i_poly : '0);
  end

endmodule

// File: rtl/crc_engine.sv
// Bit-serial CRC generate/check engine (IDLE -> SHIFT -> DONE).
// Optional macro CRC_INJECT_EN adds an error-injection input on the bus.
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned G_W = 5,
  parameter int unsigned D_W = 14
) (
  input logic         clk,
  input logic         reset,
  crc_engine_if.slave bus
);

  localparam int unsigned N  = D_W + G_W - 1;
  localparam int unsigned CW = $clog2(N + 1);

  state_e          r_state, w_state_nxt;
  logic [D_W-1:0]  r_data;
  logic [G_W-2:0]  r_tail;
  logic [G_W-2:0]  r_poly;
  logic [G_W-2:0]  r_rem;
  logic [N-1:0]    r_stream;
  logic            r_mode;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_status;

  logic            w_accept;
  logic            w_last;
  logic            w_poly_ok;
  logic [D_W-1:0]  w_data_lat;
  logic [G_W-2:0]  w_rem_nxt;

  assign w_accept  = (r_state != SHIFT) && bus.start;
  assign w_last    = (r_state == SHIFT) && (r_cnt == CW'(N - 1));
  assign w_poly_ok = bus.G[G_W-1];

`ifdef CRC_INJECT_EN
  assign w_data_lat = bus.data_in ^ D_W'(bus.inject_err);
`else
  assign w_data_lat = bus.data_in;
`endif

  crc_div_step #(
    .G_W (G_W)
  ) u_div_step (
    .i_rem  (r_rem),
    .i_bit  (r_stream[N-1]),
    .i_poly (r_poly),
    .o_rem  (w_rem_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE, DONE: begin
        if (bus.start) begin
          w_state_nxt = w_poly_ok ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: operands are captured once on accept so later input changes
  // cannot disturb a running division.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_tail   <= '0;
      r_poly   <= '0;
      r_rem    <= '0;
      r_stream <= '0;
      r_mode   <= 1'b0;
      r_cnt    <= '0;
      r_status <= NONE;
    end else if (w_accept) begin
      r_data   <= w_data_lat;
      r_tail   <= bus.crc_in;
      r_poly   <= bus.G[G_W-2:0];
      r_mode   <= bus.mode;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_stream <= bus.mode ? {w_data_lat, bus.crc_in} : {w_data_lat, {(G_W-1){1'b0}}};
      r_status <= w_poly_ok ? NONE : BADPOLY;
    end else if (r_state == SHIFT) begin
      r_rem    <= w_rem_nxt;
      r_stream <= r_stream << 1;
      r_cnt    <= r_cnt + CW'(1);
      if (w_last) begin
        if (!r_mode) begin
          r_status <= PASS;
        end else begin
          r_status <= (w_rem_nxt == '0) ? PASS : FAIL;
        end
      end
    end
  end

  always_comb begin
    bus.busy      = (r_state == SHIFT);
    bus.done      = (r_state == DONE);
    bus.status    = r_status;
    bus.error     = r_status[1];
    bus.remainder = '0;
    bus.codeword  = '0;
    if (r_state == DONE) begin
      bus.remainder = r_rem;
      bus.codeword  = {r_data, (r_mode ? r_tail : r_rem)};
    end
  end

endmodule
